cw305_ascon_sched: RTL
======================

Name: cw305_ascon_sched

Overview:
Batch sequencer between the register block and the Ascon bridge, in the crypto clock domain. On one command it runs the core N times. Each run is: init pulse, start pulse, wait for busy to complete, then an optional idle gap. It captures the output words into a small buffer, raises a trigger window for each run, enforces a per-run timeout, and reports status for SCA trace batching.

Parameters:
pWORD_W, 32, width of core output word
pOUT_WORDS, 8, output buffer depth (power of 2); pOA_W = $clog2(pOUT_WORDS)
pRUNS_W, 16, run counter width
pTO_W, 16, timeout counter width

Ports:
clk  in  1  crypto clock; all logic on rising edge
rst  in  1  asynchronous, active-low reset
cmd_go  in  1  single-cycle pulse; start batch
cmd_abort  in  1  single-cycle pulse; stop batch
cfg_runs  in  pRUNS_W  runs per batch; 0 treated as 1
cfg_gap  in  8  idle cycles between runs
cfg_timeout  in  pTO_W  max cycles per run in RUN; 0 disables
core_init  out  1  to bridge init
core_start  out  1  to bridge start
core_busy  in  1  from bridge busy
core_val  in  1  from bridge val_dout
core_waddr  in  8  from bridge waddr
core_dout  in  pWORD_W  from bridge dout
out_rd_addr  in  pOA_W  buffer read address
out_rd_data  out  pWORD_W  buffer word, registered (1-cycle read latency)
sts_busy  out  1  batch in progress (state != IDLE)
sts_done  out  1  sticky; batch completed normally
sts_timeout  out  1  sticky; batch ended by timeout
sts_ovf  out  1  sticky; core_waddr >= pOUT_WORDS seen
sts_run_cnt  out  pRUNS_W  completed runs in current/last batch
trig_o  out  1  trigger window

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs, counters, sticky flags and buffer entries are 0.
- FSM states: IDLE, INIT, START, RUN, GAP. State is registered. core_init=1 only in INIT; core_start=1 only in START. Both are therefore exactly 1-cycle pulses.
- IDLE:
  - cmd_go=1 and cmd_abort=0: clear sts_done/timeout/ovf, run_cnt=0, latch runs_eff=max(cfg_runs,1), go to INIT.
  - cmd_go at edge k gives core_init high in cycle k+1 and core_start high in cycle k+2.
- INIT -> START unconditionally.
- START -> RUN. seen_busy=0; to_cnt=0.
- RUN:
  - core_busy=1 sets seen_busy.
  - Run completes when seen_busy=1 and core_busy=0.
  - On completion, run_cnt+1. If the new run_cnt == runs_eff: set sts_done, go to IDLE. Otherwise go to GAP with gap_cnt=0.
  - to_cnt increments each RUN cycle. If cfg_timeout!=0 and to_cnt==cfg_timeout-1 while the run is not yet complete: set sts_timeout, go to IDLE, run_cnt unchanged.
  - Completion and timeout in the same cycle: completion wins.
- GAP: increment gap_cnt. When gap_cnt==cfg_gap, go to INIT. cfg_gap=0 gives exactly one GAP cycle.
- cmd_abort in any non-IDLE state: go to IDLE next edge. No pulse is emitted in that edge's next cycle. sts_done stays 0; other flags are kept. Abort has priority over go, completion and timeout.
- cmd_go while not IDLE is ignored. cfg_* are sampled only where used; software holds them stable during a batch.
- Capture (any state):
  - core_val=1 and core_waddr<pOUT_WORDS: buf[core_waddr[pOA_W-1:0]] <= core_dout.
  - core_val=1 and core_waddr>=pOUT_WORDS: write is dropped and sts_ovf is set.
  - Later runs overwrite entries, so the buffer holds the last written value per address.
- trig_o = (state==RUN) & core_busy, registered from the same edge as state. No trigger outside a sequenced run.
- run_cnt saturates at all-ones; it cannot overflow because runs_eff <= 2^pRUNS_W-1.

Decomposition:
- Package ascon_sched_pkg holds:
  - the state encoding typedef (IDLE=0, INIT=1, START=2, RUN=3, GAP=4);
  - the default widths.
- One sub-module, ascon_sched_outbuf: pOUT_WORDS x pWORD_W register file with one write port and a registered read port.
- FSM, counters and status registers live in the top.

Test Plan:
- Single run: cfg_runs=1, cfg_gap=0, timeout=0; bridge model holds busy for 20 cycles and writes waddr 0..3 = 0xA0..0xA3. Expect:
  - core_init at go+1, core_start at go+2;
  - trig_o high for exactly the 20 busy cycles;
  - sts_done=1, sts_run_cnt=1;
  - buffer reads return A0..A3.
- Batch: cfg_runs=3, cfg_gap=5, busy 10 cycles. Expect:
  - 3 init/start pairs;
  - 6 cycles from busy fall to the next core_init;
  - sts_run_cnt=3, sts_done=1.
- Timeout: cfg_timeout=8; model never raises busy. Expect sts_timeout=1 after 8 RUN cycles, sts_done=0, sts_busy=0, run_cnt=0.
- Abort: cmd_abort during GAP of a 4-run batch after run 2. Expect IDLE next cycle, no further core_init, run_cnt=2, sts_done=0. Go and abort issued together in IDLE leaves state IDLE.
- Overflow and edges:
  - waddr=9 with pOUT_WORDS=8 sets sts_ovf and leaves buffer unchanged;
  - cfg_runs=0 executes exactly 1 run;
  - rst asserted mid-RUN clears everything asynchronously.

Source files
------------

// File: rtl/ascon_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ascon_sched_pkg
// Brief    : Shared state encoding and default widths for the Ascon batch
//            sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package ascon_sched_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_START = 3'd2,
        ST_RUN   = 3'd3,
        ST_GAP   = 3'd4
    } sched_state_t;

    // Default widths
    localparam int c_WORD_W    = 32;
    localparam int c_OUT_WORDS = 8;
    localparam int c_RUNS_W    = 16;
    localparam int c_TO_W      = 16;

endpackage : ascon_sched_pkg
`default_nettype wire

// File: rtl/ascon_sched_outbuf.sv
`default_nettype none
// ============================================================================
// Module   : ascon_sched_outbuf
// Brief    : Small output-word register file, one write port and a
//            registered read port (1-cycle read latency).
// Revision : 1.0 - initial release
// ============================================================================
module ascon_sched_outbuf
    import ascon_sched_pkg::*;
#(
    parameter int pWORD_W    = c_WORD_W,
    parameter int pOUT_WORDS = c_OUT_WORDS,
    parameter int pOA_W      = $clog2(pOUT_WORDS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [pOA_W-1:0]   waddr,
    input  logic [pWORD_W-1:0] wdata,
    input  logic [pOA_W-1:0]   rd_addr,
    output logic [pWORD_W-1:0] rd_data
);

    logic [pWORD_W-1:0] r_mem [pOUT_WORDS];

    // Storage array: cleared on reset, one write per cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < pOUT_WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Registered read port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= r_mem[rd_addr];
        end
    end

endmodule : ascon_sched_outbuf
`default_nettype wire

// File: rtl/cw305_ascon_sched.sv
`default_nettype none
// ============================================================================
// Module   : cw305_ascon_sched
// Brief    : Batch sequencer for the Ascon bridge. Runs the core N times
//            (init, start, wait busy, gap), captures output words, raises a
//            trigger window per run, enforces a per-run timeout and reports
//            sticky status for trace batching.
// Revision : 1.0 - initial release
// ============================================================================
module cw305_ascon_sched
    import ascon_sched_pkg::*;
#(
    parameter int pWORD_W    = c_WORD_W,
    parameter int pOUT_WORDS = c_OUT_WORDS,
    parameter int pRUNS_W    = c_RUNS_W,
    parameter int pTO_W      = c_TO_W,
    parameter int pOA_W      = $clog2(pOUT_WORDS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_go,
    input  logic               cmd_abort,
    input  logic [pRUNS_W-1:0] cfg_runs,
    input  logic [7:0]         cfg_gap,
    input  logic [pTO_W-1:0]   cfg_timeout,
    output logic               core_init,
    output logic               core_start,
    input  logic               core_busy,
    input  logic               core_val,
    input  logic [7:0]         core_waddr,
    input  logic [pWORD_W-1:0] core_dout,
    input  logic [pOA_W-1:0]   out_rd_addr,
    output logic [pWORD_W-1:0] out_rd_data,
    output logic               sts_busy,
    output logic               sts_done,
    output logic               sts_timeout,
    output logic               sts_ovf,
    output logic [pRUNS_W-1:0] sts_run_cnt,
    output logic               trig_o
);

    localparam logic [7:0] c_OUT_LIMIT = 8'(pOUT_WORDS);

    sched_state_t       r_state;
    logic [pRUNS_W-1:0] r_runs_eff;
    logic [pTO_W-1:0]   r_to_cnt;
    logic [7:0]         r_gap_cnt;
    logic               r_seen_busy;

    logic               w_wr_ok;
    logic               w_wr_ovf;
    logic               w_run_done;
    logic               w_to_hit;
    logic [pRUNS_W-1:0] w_run_cnt_inc;

    assign w_wr_ok       = core_val && (core_waddr <  c_OUT_LIMIT);
    assign w_wr_ovf      = core_val && (core_waddr >= c_OUT_LIMIT);
    assign w_run_done    = r_seen_busy && !core_busy;
    assign w_to_hit      = (cfg_timeout != '0) && (r_to_cnt == cfg_timeout - pTO_W'(1));
    assign w_run_cnt_inc = (&sts_run_cnt) ? sts_run_cnt : sts_run_cnt + pRUNS_W'(1);
    assign sts_busy      = (r_state != ST_IDLE);

    // Sequencer FSM with registered pulses, trigger, counters and sticky status
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_runs_eff  <= '0;
            r_to_cnt    <= '0;
            r_gap_cnt   <= '0;
            r_seen_busy <= 1'b0;
            core_init   <= 1'b0;
            core_start  <= 1'b0;
            trig_o      <= 1'b0;
            sts_done    <= 1'b0;
            sts_timeout <= 1'b0;
            sts_ovf     <= 1'b0;
            sts_run_cnt <= '0;
        end else begin
            core_init  <= 1'b0;
            core_start <= 1'b0;
            trig_o     <= 1'b0;
            if (cmd_abort && (r_state != ST_IDLE)) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (cmd_go && !cmd_abort) begin
                            sts_done    <= 1'b0;
                            sts_timeout <= 1'b0;
                            sts_ovf     <= 1'b0;
                            sts_run_cnt <= '0;
                            r_runs_eff  <= (cfg_runs == '0) ? pRUNS_W'(1) : cfg_runs;
                            r_state     <= ST_INIT;
                            core_init   <= 1'b1;
                        end
                    end
                    ST_INIT: begin
                        r_state    <= ST_START;
                        core_start <= 1'b1;
                    end
                    ST_START: begin
                        r_state     <= ST_RUN;
                        r_seen_busy <= 1'b0;
                        r_to_cnt    <= '0;
                    end
                    ST_RUN: begin
                        if (core_busy) begin
                            r_seen_busy <= 1'b1;
                        end
                        r_to_cnt <= r_to_cnt + pTO_W'(1);
                        // Completion takes precedence over a coincident timeout
                        if (w_run_done) begin
                            sts_run_cnt <= w_run_cnt_inc;
                            if (w_run_cnt_inc == r_runs_eff) begin
                                sts_done <= 1'b1;
                                r_state  <= ST_IDLE;
                            end else begin
                                r_gap_cnt <= '0;
                                r_state   <= ST_GAP;
                            end
                        end else if (w_to_hit) begin
                            sts_timeout <= 1'b1;
                            r_state     <= ST_IDLE;
                        end else begin
                            trig_o <= core_busy;
                        end
                    end
                    ST_GAP: begin
                        if (r_gap_cnt == cfg_gap) begin
                            r_state   <= ST_INIT;
                            core_init <= 1'b1;
                        end else begin
                            r_gap_cnt <= r_gap_cnt + 8'd1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
            // Overflow is recorded after the go-clear so a coincident bad write sticks
            if (w_wr_ovf) begin
                sts_ovf <= 1'b1;
            end
        end
    end

    ascon_sched_outbuf #(
        .pWORD_W    (pWORD_W),
        .pOUT_WORDS (pOUT_WORDS),
        .pOA_W      (pOA_W)
    ) u_outbuf (
        .clk     (clk),
        .rst     (rst),
        .we      (w_wr_ok),
        .waddr   (core_waddr[pOA_W-1:0]),
        .wdata   (core_dout),
        .rd_addr (out_rd_addr),
        .rd_data (out_rd_data)
    );

endmodule : cw305_ascon_sched
`default_nettype wire
